// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined RV32 control unit: opcodes, ALUOp codes
// and the control bundle that travels ID -> EX.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       alusrc;
    logic       pcsel;
    logic       ret;
    logic [1:0] aluop;
    logic       upper;
    logic       pcrel;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle, effective rd, source usage and
// illegal flag. lui/auipc decode only when CTRL_PIPE_UPPER_IMM_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [6:0]            opcode_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  output ctrl_bundle_t          ctrl,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  use_rs1,
  output logic                  use_rs2,
  output logic                  illegal
);

  // Opcode table; unknown opcodes yield a bubble with rd cleared
  always_comb begin
    ctrl    = BUBBLE;
    rd      = rd_id;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    case (opcode_id)
      OPC_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_RTYPE;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
        use_rs1       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        rd            = '0;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALUOP_BRANCH;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        rd          = '0;
      end
      OPC_OP_IMM: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_IMM;
        use_rs1       = 1'b1;
      end
      OPC_JALR: begin
        ctrl.pcsel    = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        use_rs1       = 1'b1;
      end
      OPC_JAL: begin
        ctrl.ret      = 1'b1;
        ctrl.jump     = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
`ifdef CTRL_PIPE_UPPER_IMM_EN
      OPC_LUI: begin
        ctrl.upper    = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
      OPC_AUIPC: begin
        ctrl.pcrel    = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALUOP_ADD;
      end
`endif
      default: begin
        illegal = 1'b1;
        rd      = '0;
      end
    endcase
    // Writes to x0 are dropped at decode so later stages never see them
    if (rd == '0) ctrl.regwrite = 1'b0;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes in ID, carries controls through ID/EX, EX/MEM
// and MEM/WB, inserts bubbles for load-use and taken branches, and counts them.
// Optional lui/auipc support via CTRL_PIPE_UPPER_IMM_EN (see ctrl_decode).
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  branch_taken_ex,
  input  logic                  stall_ext,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_alusrc,
  output logic                  ex_pcsel,
  output logic                  ex_return,
  output logic [1:0]            ex_aluop,
  output logic                  ex_upper,
  output logic                  ex_pcrel,
  output logic                  ex_memread,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_memread,
  output logic                  mem_memwrite,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_regwrite,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_regwrite,
  output logic                  wb_memtoreg,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  illegal_id,
  output logic [CNT_W-1:0]      bubble_cnt
);

  ctrl_bundle_t          dec_ctrl;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic                  use_rs1, use_rs2, dec_illegal;

  ctrl_bundle_t          ex_q, ex_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  mem_memread_q, mem_memwrite_q, mem_regwrite_q, mem_memtoreg_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;
  logic                  wb_regwrite_q, wb_memtoreg_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  load_use, inject;

  ctrl_decode #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_decode (
    .opcode_id (opcode_id),
    .rd_id     (rd_id),
    .ctrl      (dec_ctrl),
    .rd        (dec_rd),
    .use_rs1   (use_rs1),
    .use_rs2   (use_rs2),
    .illegal   (dec_illegal)
  );

  // Hazard detection; a taken branch overrides load-use, stall_ext overrides both
  always_comb begin
    load_use    = ex_q.memread && (ex_rd_q != '0) &&
                  ((use_rs1 && (rs1_id == ex_rd_q)) || (use_rs2 && (rs2_id == ex_rd_q)));
    inject      = branch_taken_ex || load_use;
    stall_if_id = stall_ext || (load_use && !branch_taken_ex);
    flush_if_id = branch_taken_ex && !stall_ext;
    illegal_id  = dec_illegal;
  end

  // Next EX contents and saturating bubble counter
  always_comb begin
    ex_d    = inject ? BUBBLE : dec_ctrl;
    ex_rd_d = inject ? '0 : dec_rd;
    cnt_d   = cnt_q;
    if (inject && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Pipeline registers; stall_ext freezes every stage and the counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q           <= BUBBLE;
      ex_rd_q        <= '0;
      mem_memread_q  <= 1'b0;
      mem_memwrite_q <= 1'b0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= 1'b0;
      mem_rd_q       <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_memtoreg_q  <= 1'b0;
      wb_rd_q        <= '0;
      cnt_q          <= '0;
    end else if (!stall_ext) begin
      ex_q           <= ex_d;
      ex_rd_q        <= ex_rd_d;
      mem_memread_q  <= ex_q.memread;
      mem_memwrite_q <= ex_q.memwrite;
      mem_regwrite_q <= ex_q.regwrite;
      mem_memtoreg_q <= ex_q.memtoreg;
      mem_rd_q       <= ex_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_memtoreg_q  <= mem_memtoreg_q;
      wb_rd_q        <= mem_rd_q;
      cnt_q          <= cnt_d;
    end
  end

  // Output mapping
  always_comb begin
    ex_branch    = ex_q.branch;
    ex_jump      = ex_q.jump;
    ex_alusrc    = ex_q.alusrc;
    ex_pcsel     = ex_q.pcsel;
    ex_return    = ex_q.ret;
    ex_aluop     = ex_q.aluop;
    ex_upper     = ex_q.upper;
    ex_pcrel     = ex_q.pcrel;
    ex_memread   = ex_q.memread;
    ex_rd        = ex_rd_q;
    mem_memread  = mem_memread_q;
    mem_memwrite = mem_memwrite_q;
    mem_regwrite = mem_regwrite_q;
    mem_rd       = mem_rd_q;
    wb_regwrite  = wb_regwrite_q;
    wb_memtoreg  = wb_memtoreg_q;
    wb_rd        = wb_rd_q;
    bubble_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized traffic
// against a behavioural model of the control pipeline.
module tb_ctrl_pipe;

  localparam int unsigned RW      = 5;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    opcode_id = '0;
  logic [RW-1:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
  logic          branch_taken_ex = 1'b0, stall_ext = 1'b0;
  logic          ex_branch, ex_jump, ex_alusrc, ex_pcsel, ex_return, ex_upper, ex_pcrel;
  logic [1:0]    ex_aluop;
  logic          ex_memread, mem_memread, mem_memwrite, mem_regwrite;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
  logic          wb_regwrite, wb_memtoreg, stall_if_id, flush_if_id, illegal_id;
  logic [CNT_W-1:0] bubble_cnt;

  ctrl_pipe #(
    .REG_ADDR_W (RW),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .opcode_id       (opcode_id),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rd_id           (rd_id),
    .branch_taken_ex (branch_taken_ex),
    .stall_ext       (stall_ext),
    .ex_branch       (ex_branch),
    .ex_jump         (ex_jump),
    .ex_alusrc       (ex_alusrc),
    .ex_pcsel        (ex_pcsel),
    .ex_return       (ex_return),
    .ex_aluop        (ex_aluop),
    .ex_upper        (ex_upper),
    .ex_pcrel        (ex_pcrel),
    .ex_memread      (ex_memread),
    .ex_rd           (ex_rd),
    .mem_memread     (mem_memread),
    .mem_memwrite    (mem_memwrite),
    .mem_rd          (mem_rd),
    .mem_regwrite    (mem_regwrite),
    .wb_rd           (wb_rd),
    .wb_regwrite     (wb_regwrite),
    .wb_memtoreg     (wb_memtoreg),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .illegal_id      (illegal_id),
    .bubble_cnt      (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: one record per pipeline slot
  typedef struct packed {
    logic       branch, jump, alusrc, pcsel, ret;
    logic [1:0] aluop;
    logic       upper, pcrel, memread, memwrite, regwrite, memtoreg;
    logic [4:0] rd;
  } slot_t;

  slot_t m_ex, m_mem, m_wb, m_dec;
  int    m_cnt;
  bit    m_lu, m_use1, m_use2, m_ill, exp_stall, exp_flush;
  int    checks = 0;
  int    errors = 0;

  logic [31:0] dut_vec;
  assign dut_vec = {ex_branch, ex_jump, ex_alusrc, ex_pcsel, ex_return, ex_aluop, ex_upper,
                    ex_pcrel, ex_memread, ex_rd, mem_memread, mem_memwrite, mem_rd,
                    mem_regwrite, wb_rd, wb_regwrite, wb_memtoreg, bubble_cnt};

  function automatic logic [31:0] exp_vec();
    return {m_ex.branch, m_ex.jump, m_ex.alusrc, m_ex.pcsel, m_ex.ret, m_ex.aluop, m_ex.upper,
            m_ex.pcrel, m_ex.memread, m_ex.rd, m_mem.memread, m_mem.memwrite, m_mem.rd,
            m_mem.regwrite, m_wb.rd, m_wb.regwrite, m_wb.memtoreg, CNT_W'(m_cnt)};
  endfunction

  // What each instruction class asks of the pipeline, straight from the ISA table
  function automatic slot_t spec_decode(input logic [6:0] op, input logic [4:0] rd,
                                        output bit u1, output bit u2, output bit ill);
    slot_t s = '0;
    u1 = 0; u2 = 0; ill = 0;
    s.rd = rd;
    case (op)
      7'b0110011: begin s.regwrite = 1; s.aluop = 2'b10; u1 = 1; u2 = 1; end
      7'b0000011: begin s.memread = 1; s.memtoreg = 1; s.alusrc = 1; s.regwrite = 1; u1 = 1; end
      7'b0100011: begin s.memwrite = 1; s.alusrc = 1; u1 = 1; u2 = 1; s.rd = 0; end
      7'b1100011: begin s.branch = 1; s.aluop = 2'b01; u1 = 1; u2 = 1; s.rd = 0; end
      7'b0010011: begin s.alusrc = 1; s.regwrite = 1; s.aluop = 2'b11; u1 = 1; end
      7'b1100111: begin s.pcsel = 1; s.jump = 1; s.alusrc = 1; s.regwrite = 1; u1 = 1; end
      7'b1101111: begin s.ret = 1; s.jump = 1; s.alusrc = 1; s.regwrite = 1; end
`ifdef CTRL_PIPE_UPPER_IMM_EN
      7'b0110111: begin s.upper = 1; s.alusrc = 1; s.regwrite = 1; end
      7'b0010111: begin s.pcrel = 1; s.alusrc = 1; s.regwrite = 1; end
`endif
      default: begin s = '0; ill = 1; end
    endcase
    if (s.rd == 0) s.regwrite = 0;
    return s;
  endfunction

  // Apply ID-stage inputs and derive the model's same-cycle expectations
  task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic bt, input logic se);
    opcode_id = op; rs1_id = r1; rs2_id = r2; rd_id = rd;
    branch_taken_ex = bt; stall_ext = se;
    #1;
    m_dec = spec_decode(op, rd, m_use1, m_use2, m_ill);
    m_lu  = m_ex.memread && (m_ex.rd != 0) &&
            ((m_use1 && r1 == m_ex.rd) || (m_use2 && r2 == m_ex.rd));
    exp_stall = se || (m_lu && !bt);
    exp_flush = bt && !se;
  endtask

  // Advance the model by one clock and wait for the DUT edge
  task automatic tick();
    if (reset) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
    end else if (!stall_ext) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      if (branch_taken_ex || m_lu) begin
        m_ex = '0;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_ex = m_dec;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(7'b0010011, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++;
      if (dut_vec !== 32'h0) begin
        errors++; $display("FAIL reset_state cycle %0d: got %h want 0", i, dut_vec);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    apply_reset();
    drive(7'b0110011, 1, 2, 5, 0, 0);
    checks++;
    if (illegal_id !== 1'b0) begin errors++; $display("FAIL rtype_illegal got %b want 0", illegal_id); end
    tick();
    checks++;
    if (ex_aluop !== 2'b10 || ex_rd !== 5) begin
      errors++; $display("FAIL rtype_ex aluop %b rd %0d want 10 rd 5", ex_aluop, ex_rd);
    end
    drive(7'b0010011, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (mem_regwrite !== 1'b1 || mem_rd !== 5) begin
      errors++; $display("FAIL rtype_mem regwrite %b rd %0d want 1 rd 5", mem_regwrite, mem_rd);
    end
    tick();
    checks++;
    if (wb_regwrite !== 1'b1 || wb_rd !== 5 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL rtype_wb got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    drive(7'b0000011, 1, 0, 3, 0, 0);
    tick();
    drive(7'b0110011, 3, 7, 4, 0, 0);
    checks++;
    if (stall_if_id !== 1'b1 || flush_if_id !== 1'b0) begin
      errors++; $display("FAIL loaduse_stall stall %b flush %b want 1 0", stall_if_id, flush_if_id);
    end
    tick();
    checks++;
    if (dut_vec[31:17] !== 15'h0 || bubble_cnt !== 1 || mem_memread !== 1'b1) begin
      errors++; $display("FAIL loaduse_bubble got %h want %h", dut_vec, exp_vec());
    end
    drive(7'b0110011, 3, 7, 4, 0, 0);
    checks++;
    if (stall_if_id !== 1'b0) begin errors++; $display("FAIL loaduse_release got %b want 0", stall_if_id); end
    tick();
    checks++;
    if (ex_aluop !== 2'b10 || ex_rd !== 4 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL loaduse_resume got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_flush_priority();
    apply_reset();
    drive(7'b0000011, 1, 0, 3, 0, 0);
    tick();
    drive(7'b0110011, 3, 3, 6, 1, 0);
    checks++;
    if (flush_if_id !== 1'b1 || stall_if_id !== 1'b0) begin
      errors++; $display("FAIL flush_prio flush %b stall %b want 1 0", flush_if_id, stall_if_id);
    end
    tick();
    checks++;
    if (dut_vec[31:17] !== 15'h0 || bubble_cnt !== 1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL flush_bubble got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(7'b0000000, 1, 2, 9, 0, 0);
    checks++;
    if (illegal_id !== 1'b1 || stall_if_id !== 1'b0) begin
      errors++; $display("FAIL illegal_flag got %b want 1", illegal_id);
    end
    tick();
    checks++;
    if (dut_vec[31:17] !== 15'h0 || bubble_cnt !== 0) begin
      errors++; $display("FAIL illegal_bubble got %h want ex zero cnt 0", dut_vec);
    end
  endtask

  task automatic test_stall_ext();
    logic [31:0] frozen;
    apply_reset();
    drive(7'b0000011, 1, 0, 2, 0, 0); tick();
    drive(7'b0110011, 4, 5, 5, 0, 0); tick();
    drive(7'b0100011, 6, 7, 8, 0, 0); tick();
    frozen = exp_vec();
    for (int i = 0; i < 4; i++) begin
      drive(7'($urandom), 2, 5, 5'($urandom), 1'($urandom), 1);
      checks++;
      if (stall_if_id !== 1'b1 || flush_if_id !== 1'b0) begin
        errors++; $display("FAIL stallext_ctl %0d stall %b flush %b want 1 0", i, stall_if_id, flush_if_id);
      end
      tick();
      checks++;
      if (dut_vec !== frozen) begin
        errors++; $display("FAIL stallext_hold %0d got %h want %h", i, dut_vec, frozen);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(7'b0010011, 1, 0, 1, 0, 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stallext_resume %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    reset = 1'b1;
    drive(7'b0110011, 1, 2, 3, 0, 1);
    tick();
    reset = 1'b0;
    checks++;
    if (dut_vec !== 32'h0) begin errors++; $display("FAIL reset_in_stall got %h want 0", dut_vec); end
  endtask

  task automatic test_saturation();
    int want;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(7'b0110011, 1, 2, 3, 1, 0);
      checks++;
      if (flush_if_id !== 1'b1) begin errors++; $display("FAIL sat_flush %0d got %b want 1", i, flush_if_id); end
      tick();
      want = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
      checks++;
      if (bubble_cnt !== CNT_W'(want)) begin
        errors++; $display("FAIL sat_count %0d got %0d want %0d", i, bubble_cnt, want);
      end
    end
  endtask

  task automatic test_upper_imm();
    apply_reset();
    drive(7'b0110111, 0, 0, 6, 0, 0);
`ifdef CTRL_PIPE_UPPER_IMM_EN
    checks++;
    if (illegal_id !== 1'b0) begin errors++; $display("FAIL lui_legal got %b want 0", illegal_id); end
    tick();
    checks++;
    if (ex_upper !== 1'b1 || ex_alusrc !== 1'b1 || ex_aluop !== 2'b00 || ex_rd !== 6) begin
      errors++; $display("FAIL lui_ex got %h want %h", dut_vec, exp_vec());
    end
    drive(7'b0010111, 0, 0, 7, 0, 0);
    tick();
    checks++;
    if (ex_pcrel !== 1'b1 || ex_upper !== 1'b0 || ex_rd !== 7) begin
      errors++; $display("FAIL auipc_ex got %h want %h", dut_vec, exp_vec());
    end
`else
    checks++;
    if (illegal_id !== 1'b1) begin errors++; $display("FAIL lui_illegal got %b want 1", illegal_id); end
    tick();
    checks++;
    if (dut_vec[31:17] !== 15'h0) begin errors++; $display("FAIL lui_bubble got %h want ex zero", dut_vec); end
    drive(7'b0010111, 0, 0, 7, 0, 0);
    checks++;
    if (illegal_id !== 1'b1) begin errors++; $display("FAIL auipc_illegal got %b want 1", illegal_id); end
    tick();
    checks++;
    if (ex_pcrel !== 1'b0 || ex_rd !== 0) begin errors++; $display("FAIL auipc_bubble got %h", dut_vec); end
`endif
  endtask

  task automatic test_random();
    logic [6:0] ops [10] = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011,
                             7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0000000};
    logic [6:0] op;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      drive(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      checks++;
      if ({stall_if_id, flush_if_id, illegal_id} !== {exp_stall, exp_flush, m_ill}) begin
        errors++;
        $display("FAIL rand_comb %0d got %b%b%b want %b%b%b", i, stall_if_id, flush_if_id,
                 illegal_id, exp_stall, exp_flush, m_ill);
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL rand_state %0d got %h want %h", i, dut_vec, exp_vec());
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_ex = '0; m_mem = '0; m_wb = '0; m_dec = '0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_rtype();
    test_load_use();
    test_flush_priority();
    test_illegal();
    test_stall_ext();
    test_saturation();
    test_upper_imm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
